button_conditioner: RTL and testbench

- Multi-channel successor to the single-pulse button FSM.
- Each channel has three stages:
  - a 2-flop synchroniser;
  - a counter-based debouncer;
  - a per-channel press/release FSM.
- Each channel outputs:
  - a one-cycle press pulse;
  - an optional auto-repeat pulse train while held;
  - a one-cycle release pulse;
  - a debounced level.
- Sits between the board pushbuttons and the game/menu control logic, replacing per-button shaper instances.

---
 rtl/button_conditioner.sv | 95 +++++++++
 tb/tb_button_conditioner.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronise, debounce, press/repeat/release pulse shaping
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_level
);
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
  localparam int CW = cnt_w(DEBOUNCE_CYCLES, REPEAT_DELAY);
  localparam logic [CW-1:0] DC  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RD  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RL  = CW'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [1:0] IDLE = 2'd0, PRESS_DB = 2'd1, HELD = 2'd2, RELEASE_DB = 2'd3;
  localparam logic [N_BTN-1:0] REL = ACTIVE_LOW != 0 ? '1 : '0;
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_param
    $error("button_conditioner: unsupported parameter values");
  end
  logic [N_BTN-1:0] s1, s2, p;
  always_ff @(posedge clk)
    if (!reset) begin
      s1 <= REL;
      s2 <= REL;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  assign p = ACTIVE_LOW != 0 ? ~s2 : s2;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0] st;
    logic [CW-1:0] dcnt, rcnt;
    logic pl, rl, ll;
    always_ff @(posedge clk)
      if (!reset) begin
        st   <= IDLE;
        dcnt <= '0;
        rcnt <= '0;
        pl   <= 1'b0;
        rl   <= 1'b0;
        ll   <= 1'b0;
      end else begin
        pl <= 1'b0;
        rl <= 1'b0;
        case (st)
          IDLE:
            if (p[i]) begin
              st   <= PRESS_DB;
              dcnt <= ONE;
            end
          PRESS_DB:
            if (!p[i]) begin
              st   <= IDLE;
              dcnt <= '0;
            end else if (dcnt == DC) begin
              st   <= HELD;
              pl   <= 1'b1;
              ll   <= 1'b1;
              rcnt <= '0;
            end else dcnt <= dcnt + ONE;
          HELD:
            if (!p[i]) begin
              st   <= RELEASE_DB;
              dcnt <= ONE;
            end else if (!repeat_en[i]) rcnt <= '0;
            else if (rcnt + ONE == RD) begin
              pl   <= 1'b1;
              rcnt <= RL;
            end else rcnt <= rcnt + ONE;
          default:
            if (p[i]) st <= HELD;
            else if (dcnt == DC) begin
              st   <= IDLE;
              rl   <= 1'b1;
              ll   <= 1'b0;
              dcnt <= '0;
              rcnt <= '0;
            end else dcnt <= dcnt + ONE;
        endcase
      end
    assign btn_pulse[i]   = pl;
    assign btn_release[i] = rl;
    assign btn_level[i]   = ll;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench with run-length reference model, both polarities
module tb_button_conditioner;
  localparam int N = 4, D = 4, RD = 20, RP = 8;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] press, ren;
  logic [N-1:0] bp_a, br_a, bl_a, bp_b, br_b, bl_b;
  logic [N-1:0] btn_a, btn_b;
  assign btn_a = ~press;
  assign btn_b = press;
  always #5 clk = ~clk;
  button_conditioner #(.N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
    .clk(clk), .reset(reset), .btn_in(btn_a), .repeat_en(ren),
    .btn_pulse(bp_a), .btn_release(br_a), .btn_level(bl_a));
  button_conditioner #(.N_BTN(N), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .clk(clk), .reset(reset), .btn_in(btn_b), .repeat_en(ren),
    .btn_pulse(bp_b), .btn_release(br_b), .btn_level(bl_b));
  int tests = 0, fails = 0;
  logic [3*N-1:0] q[$];
  logic [N-1:0] d1, d2, lvl, ep, er;
  int run [N];
  int held[N];
  always @(posedge clk) begin
    ep = '0;
    er = '0;
    if (!reset) begin
      d1 = '0;
      d2 = '0;
      lvl = '0;
      for (int c = 0; c < N; c++) begin
        run[c] = 0;
        held[c] = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (d2[c] == lvl[c]) begin
          if (lvl[c] && run[c] == 0) begin
            if (!ren[c]) held[c] = 0;
            else begin
              held[c]++;
              if (held[c] >= RD && (held[c] - RD) % RP == 0) ep[c] = 1'b1;
            end
          end
          run[c] = 0;
        end else begin
          run[c]++;
          if (run[c] == D + 1) begin
            lvl[c] = ~lvl[c];
            run[c] = 0;
            held[c] = 0;
            if (lvl[c]) ep[c] = 1'b1;
            else er[c] = 1'b1;
          end
        end
      end
      d2 = d1;
      d1 = press;
    end
    q.push_back({ep, er, lvl});
  end
  logic [3*N-1:0] e;
  logic [N-1:0] prev_p = '0;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if ({bp_a, br_a, bl_a} !== e) begin
        fails++;
        $display("FAIL outputs_low t=%0t got=%h exp=%h", $time, {bp_a, br_a, bl_a}, e);
      end
      tests++;
      if ({bp_b, br_b, bl_b} !== e) begin
        fails++;
        $display("FAIL outputs_high t=%0t got=%h exp=%h", $time, {bp_b, br_b, bl_b}, e);
      end
      tests++;
      if ((bp_a & br_a) != '0 || (bp_a & prev_p) != '0) begin
        fails++;
        $display("FAIL pulse_rules t=%0t pulse=%b release=%b prev=%b exp=no overlap", $time, bp_a, br_a, prev_p);
      end
      prev_p = bp_a;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int pk;
    reset = 1'b0;
    press = '0;
    ren = '0;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    press[0] = 1'b1;
    pk = -1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bp_a[0] && pk < 0) pk = k;
    end
    tests++;
    if (pk != D + 2) begin
      fails++;
      $display("FAIL press_latency got=%0d exp=%0d", pk, D + 2);
    end
    cyc(30);
    press[0] = 1'b0;
    cyc(10);
    press[1] = 1'b1; cyc(3);
    press[1] = 1'b0; cyc(1);
    press[1] = 1'b1; cyc(20);
    press[1] = 1'b0; cyc(10);
    ren[2] = 1'b1;
    press[2] = 1'b1; cyc(70);
    press[2] = 1'b0; cyc(10);
    ren[2] = 1'b0;
    press[3] = 1'b1; cyc(15);
    press[3] = 1'b0; cyc(2);
    press[3] = 1'b1; cyc(10);
    press[3] = 1'b0; cyc(10);
    ren[0] = 1'b1;
    press[0] = 1'b1; cyc(35);
    reset = 1'b0; cyc(1);
    reset = 1'b1; cyc(15);
    press[0] = 1'b0; cyc(10);
    ren = '0;
    press = '1; cyc(30);
    press = '0; cyc(10);
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(7) == 0) press[c] = ~press[c];
        if ($urandom_range(31) == 0) ren[c] = ~ren[c];
      end
      reset = $urandom_range(499) != 0;
      if (k % 600 < 300 && $urandom_range(1) == 0) press = press;
      else if (k % 600 >= 300 && $urandom_range(15) != 0) press = press & {N{1'b1}};
      cyc(k % 600 >= 300 ? 1 + $urandom_range(30) : 1);
    end
    reset = 1'b1;
    press = '0;
    cyc(12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
